// File: rtl/uart_apb_csr_v2_pkg.sv
// uart_csr_pkg: shared constants for the UART APB CSR bank.
//   - register word offsets (paddr[4:2])
//   - IIR identification codes, LSR / IER / FCR bit positions
//   - RX trigger encoding and a helper that maps it to a FIFO level
package uart_csr_pkg;

  // Word offsets, decoded from paddr[4:2]
  localparam logic [2:0] OFF_RBR = 3'd0;  // THR on write
  localparam logic [2:0] OFF_IER = 3'd1;
  localparam logic [2:0] OFF_FCR = 3'd2;  // IIR on read
  localparam logic [2:0] OFF_LCR = 3'd3;
  localparam logic [2:0] OFF_DIV = 3'd4;
  localparam logic [2:0] OFF_LSR = 3'd5;
  localparam logic [2:0] OFF_SCR = 3'd6;
  localparam logic [2:0] OFF_LVL = 3'd7;

  typedef enum logic [3:0] {
    IIR_NONE = 4'h1,
    IIR_THRE = 4'h2,
    IIR_RDA  = 4'h4,
    IIR_LS   = 4'h6
  } iir_code_e;

  // IER bits
  localparam int IER_RDA  = 0;
  localparam int IER_THRE = 1;
  localparam int IER_LS   = 2;

  // FCR bits
  localparam int FCR_RXCLR = 1;
  localparam int FCR_TXCLR = 2;
  localparam int FCR_TRIG  = 6;  // [7:6]

  // Sticky error vector layout; matches LSR[3:1]
  localparam int ERR_OE = 0;
  localparam int ERR_PE = 1;
  localparam int ERR_FE = 2;

  typedef enum logic [1:0] {
    TRIG_ONE  = 2'd0,
    TRIG_QTR  = 2'd1,
    TRIG_HALF = 2'd2,
    TRIG_NEAR = 2'd3
  } rx_trig_e;

  function automatic int trig_level(rx_trig_e t, int depth);
    case (t)
      TRIG_ONE:  return 1;
      TRIG_QTR:  return depth / 4;
      TRIG_HALF: return depth / 2;
      default:   return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_apb_csr_v2_if.sv
// uart_apb_if: APB3 completer-side bundle for the UART CSR bank.
//   master : drives paddr/psel/penable/pwrite/pwdata, sees prdata/pready/pslverr
//   slave  : the reverse
interface uart_apb_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/uart_apb_csr_v2_irq_prio.sv
// uart_irq_prio: THRE-pending latch, fixed-priority IIR encoder, registered irq.
//   ier_i       enable bits [2:0] (LS, THRE, RDA)
//   err_any_i   any sticky line-status error
//   rda_hit_i   RX level >= trigger
//   tx_empty_i  TX FIFO empty (edge detected here)
//   thre_arm_i  IER[1] being written 0->1 while TX empty
//   thr_wr_i    accepted THR write
//   iir_rd_i    accepted IIR read
//   iir_o       current identification code, irq_o registered interrupt
module uart_irq_prio
  import uart_csr_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] ier_i,
  input  logic       err_any_i,
  input  logic       rda_hit_i,
  input  logic       tx_empty_i,
  input  logic       thre_arm_i,
  input  logic       thr_wr_i,
  input  logic       iir_rd_i,
  output iir_code_e  iir_o,
  output logic       irq_o
);

  logic thre_pend_q, thre_pend_d;
  logic tx_empty_q;
  logic ls, rda, thre;

  assign ls   = ier_i[IER_LS]   & err_any_i;
  assign rda  = ier_i[IER_RDA]  & rda_hit_i;
  assign thre = ier_i[IER_THRE] & thre_pend_q;

  always_comb begin
    iir_o = IIR_NONE;
    if (ls)        iir_o = IIR_LS;
    else if (rda)  iir_o = IIR_RDA;
    else if (thre) iir_o = IIR_THRE;
  end

  // Set wins over clear so a fresh empty edge is never lost.
  always_comb begin
    thre_pend_d = thre_pend_q;
    if (thr_wr_i || (iir_rd_i && iir_o == IIR_THRE)) thre_pend_d = 1'b0;
    if ((tx_empty_i && !tx_empty_q) || thre_arm_i)   thre_pend_d = 1'b1;
  end

  // tx_empty_q resets to 1: an idle FIFO coming out of reset is not an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      thre_pend_q <= 1'b0;
      tx_empty_q  <= 1'b1;
      irq_o       <= 1'b0;
    end else begin
      thre_pend_q <= thre_pend_d;
      tx_empty_q  <= tx_empty_i;
      irq_o       <= ls | rda | thre;
    end
  end

endmodule

// File: rtl/uart_apb_csr_v2.sv
// uart_apb_csr_v2: zero-wait APB register bank for the UART.
//   apb            APB completer (uart_apb_if.slave); prdata/pready/pslverr combinational
//   tx_fifo_*      byte push, flush, full/empty status
//   rx_fifo_*      show-ahead head byte, level, pop, flush
//   tx_busy, rx_*  engine status and single-cycle error pulses
//   lcr_q, baud_div  line control and baud divisor registers
//   irq            registered interrupt
module uart_apb_csr_v2
  import uart_csr_pkg::*;
#(
  parameter  int ADDR_WIDTH = 12,
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 16,
  parameter  int DIV_WIDTH  = 16,
  parameter  int DIV_RESET  = 1,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  uart_apb_if.slave            apb,
  output logic [7:0]           tx_fifo_wdata,
  output logic                 tx_fifo_push,
  input  logic                 tx_fifo_full,
  input  logic                 tx_fifo_empty,
  output logic                 tx_fifo_clr,
  input  logic [7:0]           rx_fifo_rdata,
  input  logic [LVL_W-1:0]     rx_fifo_level,
  output logic                 rx_fifo_pop,
  output logic                 rx_fifo_clr,
  input  logic                 tx_busy,
  input  logic                 rx_frame_err,
  input  logic                 rx_parity_err,
  input  logic                 rx_overrun,
  output logic [7:0]           lcr_q,
  output logic [DIV_WIDTH-1:0] baud_div,
  output logic                 irq
);

  logic                 acc, misal, err, wr_ok, rd_ok, rx_nz;
  logic [2:0]           off;
  logic [DIV_WIDTH-1:0] wdiv;
  logic [3:0]           ier_q, ier_d;
  logic [7:0]           lcr_d, scr_q, scr_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  rx_trig_e             trig_q, trig_d;
  logic [2:0]           err_q, err_d;
  logic [7:0]           lsr;
  logic                 lsr_rd, iir_rd, thre_arm, rda_hit;
  iir_code_e            iir;
  logic [DATA_WIDTH-1:0] rdata;
  logic                 unused_ok;

  // rstn gates the access so strobes and the response drop the moment
  // reset asserts, even in the middle of an access phase.
  assign acc   = rstn & apb.psel & apb.penable;
  assign misal = |apb.paddr[1:0];
  assign off   = apb.paddr[4:2];
  assign wdiv  = apb.pwdata[DIV_WIDTH-1:0];
  assign rx_nz = |rx_fifo_level;

  always_comb begin
    err = misal;
    if (!misal && apb.pwrite) begin
      case (off)
        OFF_RBR:          err = tx_fifo_full;
        OFF_DIV:          err = (wdiv == '0);
        OFF_LSR, OFF_LVL: err = 1'b1;
        default:          err = 1'b0;
      endcase
    end
  end

  assign wr_ok = acc &  apb.pwrite & ~err;
  assign rd_ok = acc & ~apb.pwrite & ~err;

  assign apb.pready  = acc;
  assign apb.pslverr = acc & err;

  assign tx_fifo_push  = wr_ok & (off == OFF_RBR);
  assign tx_fifo_wdata = tx_fifo_push ? apb.pwdata[7:0] : 8'h00;
  assign tx_fifo_clr   = wr_ok & (off == OFF_FCR) & apb.pwdata[FCR_TXCLR];
  assign rx_fifo_clr   = wr_ok & (off == OFF_FCR) & apb.pwdata[FCR_RXCLR];
  assign rx_fifo_pop   = rd_ok & (off == OFF_RBR) & rx_nz;

  assign lsr_rd   = rd_ok & (off == OFF_LSR);
  assign iir_rd   = rd_ok & (off == OFF_FCR);
  assign thre_arm = wr_ok & (off == OFF_IER) & apb.pwdata[IER_THRE]
                  & ~ier_q[IER_THRE] & tx_fifo_empty;
  assign rda_hit  = int'(rx_fifo_level) >= trig_level(trig_q, FIFO_DEPTH);

  assign lsr = {|err_q, tx_fifo_empty & ~tx_busy, tx_fifo_empty, 1'b0, err_q, rx_nz};

  always_comb begin
    case (off)
      OFF_RBR: rdata = rx_nz ? DATA_WIDTH'(rx_fifo_rdata) : '0;
      OFF_IER: rdata = DATA_WIDTH'(ier_q);
      OFF_FCR: rdata = DATA_WIDTH'({trig_q, 2'b00, iir});
      OFF_LCR: rdata = DATA_WIDTH'(lcr_q);
      OFF_DIV: rdata = DATA_WIDTH'(div_q);
      OFF_LSR: rdata = DATA_WIDTH'(lsr);
      OFF_SCR: rdata = DATA_WIDTH'(scr_q);
      default: rdata = DATA_WIDTH'(rx_fifo_level);
    endcase
  end

  assign apb.prdata = rd_ok ? rdata : '0;

  always_comb begin
    ier_d  = ier_q;
    lcr_d  = lcr_q;
    scr_d  = scr_q;
    div_d  = div_q;
    trig_d = trig_q;
    if (wr_ok) begin
      case (off)
        OFF_IER: ier_d  = apb.pwdata[3:0];
        OFF_FCR: trig_d = rx_trig_e'(apb.pwdata[FCR_TRIG+1:FCR_TRIG]);
        OFF_LCR: lcr_d  = apb.pwdata[7:0];
        OFF_DIV: div_d  = wdiv;
        OFF_SCR: scr_d  = apb.pwdata[7:0];
        default: ;
      endcase
    end
    // A pulse coinciding with the LSR read survives the clear.
    err_d = (lsr_rd ? 3'b000 : err_q) | {rx_frame_err, rx_parity_err, rx_overrun};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ier_q  <= '0;
      lcr_q  <= '0;
      scr_q  <= '0;
      div_q  <= DIV_WIDTH'(DIV_RESET);
      trig_q <= TRIG_ONE;
      err_q  <= '0;
    end else begin
      ier_q  <= ier_d;
      lcr_q  <= lcr_d;
      scr_q  <= scr_d;
      div_q  <= div_d;
      trig_q <= trig_d;
      err_q  <= err_d;
    end
  end

  assign baud_div = div_q;

  uart_irq_prio u_irq (
    .clk        (clk),
    .rstn       (rstn),
    .ier_i      (ier_q[2:0]),
    .err_any_i  (|err_q),
    .rda_hit_i  (rda_hit),
    .tx_empty_i (tx_fifo_empty),
    .thre_arm_i (thre_arm),
    .thr_wr_i   (tx_fifo_push),
    .iir_rd_i   (iir_rd),
    .iir_o      (iir),
    .irq_o      (irq)
  );

  // Upper address bits alias; upper write-data bits are ignored.
  assign unused_ok = ^{apb.paddr, apb.pwdata};

endmodule
